// File: rtl/dctq_quantizer.sv
// Quantizer after the DCT adder: a signed coefficient is divided by its step with a restoring divider
// that produces one quotient bit per cycle. Define DCTQ_ROUND_EN for divisor-half rounding (ties away from zero).
module dctq_quantizer #(
    parameter int DW  = 12,
    parameter int QW  = 8,
    parameter int BLK = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_dct,
    input  logic [QW-1:0]        in_qstep,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_q,
    output logic [5:0]           out_idx,
    output logic                 out_last
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

    state_t        state;
    logic          sign;
    logic [DW-1:0] num;    // holds the dividend and shifts quotient bits in at the LSB
    logic [QW-1:0] rem;
    logic [QW-1:0] div;
    logic [CW-1:0] cnt;

    logic [DW-1:0] abs_x;
    logic [DW-1:0] numer;
    logic [QW-1:0] step_fix;
    logic [QW:0]   trial;
    logic          fits;
    logic [QW-1:0] rem_next;
    logic [DW-1:0] num_next;
    logic [DW-1:0] q_signed;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        abs_x    = '0;
        numer    = '0;
        step_fix = '0;
        abs_x    = in_dct[DW-1] ? (~$unsigned(in_dct) + DW'(1)) : $unsigned(in_dct);
        step_fix = (in_qstep == '0) ? QW'(1) : in_qstep;
`ifdef DCTQ_ROUND_EN
        numer    = abs_x + DW'(step_fix >> 1);
`else
        numer    = abs_x;
`endif
    end

    always_comb begin
        trial    = {rem, num[DW-1]};
        fits     = (trial >= {1'b0, div});
        rem_next = fits ? QW'(trial - {1'b0, div}) : trial[QW-1:0];
        num_next = {num[DW-2:0], fits};
        // Negating a zero quotient gives zero, so there is no negative zero.
        q_signed = sign ? (~num_next + DW'(1)) : num_next;
    end

    assign in_ready = (state == IDLE);
    assign out_last = out_valid && (out_idx == 6'(BLK - 1));

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            num       <= '0;
            rem       <= '0;
            div       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in_dct[DW-1];
                        num   <= numer;
                        rem   <= '0;
                        div   <= step_fix;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    num <= num_next;
                    rem <= rem_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        out_q     <= q_signed;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_idx   <= (out_idx == 6'(BLK - 1)) ? 6'd0 : out_idx + 6'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dctq_quantizer.sv
// Directed bench for dctq_quantizer: signs, extremes, step 0, a full block with stalls, and mid-flight resets.
// Expected quotients follow the build: DCTQ_ROUND_EN selects the rounded values.
module tb_dctq_quantizer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] in_dct;
    logic [7:0]         in_qstep;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] out_q;
    logic [5:0]         out_idx;
    logic               out_last;

    int errors = 0;
    int checks = 0;

`ifdef DCTQ_ROUND_EN
    localparam int EXP_POS104 = 7;
    localparam int EXP_NEG104 = -7;
`else
    localparam int EXP_POS104 = 6;
    localparam int EXP_NEG104 = -6;
`endif

    dctq_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dct    (in_dct),
        .in_qstep  (in_qstep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a coefficient, wait for acceptance, then return the accept-to-valid latency.
    task automatic send(input logic signed [11:0] dct, input logic [7:0] step, output int lat);
        int budget = 0;
        in_dct   = dct;
        in_qstep = step;
        in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        check("accept_timeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_dct   = 12'sh5A5;
        in_qstep = 8'hC3;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_coef(input string tag, input logic signed [11:0] dct, input logic [7:0] step,
                            input int exp_q, input int exp_idx);
        int lat;
        send(dct, step, lat);
        check({tag, "_latency"}, lat, 12);
        check({tag, "_q"}, int'(out_q), exp_q);
        check({tag, "_idx"}, int'(out_idx), exp_idx);
        check({tag, "_last"}, int'(out_last), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, int'(out_valid), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_idx"}, int'(out_idx), 0);
        check({tag, "_out_q"}, int'(out_q), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
    endtask

    initial begin
        int lat;
        int stall;
        logic signed [11:0] held_q;
        logic [5:0] held_idx;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dct    = '0;
        in_qstep  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_state("reset");

        // Directed quotients: positive, negative, zero result, extremes, step 0.
        run_coef("pos104", 12'sd104, 8'd16, EXP_POS104, 0);
        run_coef("neg104", -12'sd104, 8'd16, EXP_NEG104, 1);
        run_coef("neg3", -12'sd3, 8'd16, 0, 2);
        run_coef("min_by1", -12'sd2048, 8'd1, -2048, 3);
        run_coef("max_by255", 12'sd2047, 8'd255, 8, 4);
        run_coef("step0", -12'sd5, 8'd0, -5, 5);

        // Full block with random gaps; outputs must hold while stalled.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("reblk");
        for (int i = 0; i < 65; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(12'(i % 64), 8'd1, lat);
            check("blk_latency", lat, 12);
            check("blk_q", int'(out_q), i % 64);
            check("blk_idx", int'(out_idx), i % 64);
            check("blk_last", int'(out_last), (i == 63) ? 1 : 0);
            held_q   = out_q;
            held_idx = out_idx;
            stall    = 0;
            out_ready = 1'($urandom_range(0, 1));
            while (!out_ready && stall < 20) begin
                tick();
                stall++;
                check("stall_valid", int'(out_valid), 1);
                check("stall_q", int'(out_q), int'(held_q));
                check("stall_idx", int'(out_idx), int'(held_idx));
                out_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick();
            out_ready = 1'b0;
            check("blk_drop", int'(out_valid), 0);
        end

        // Reset in the middle of a divide.
        in_dct   = 12'sd100;
        in_qstep = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("rst_div");

        // Advance the index, then reset during an output stall.
        run_coef("pre_stall", 12'sd50, 8'd5, 10, 0);
        send(12'sd77, 8'd7, lat);
        check("stall_pending", int'(out_valid), 1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("rst_out");
        run_coef("post_rst", -12'sd100, 8'd7, -14, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
